// File: rtl/can_stuff_engine.sv
// CAN bit-stuffing engine: inserts stuff bits on transmit, removes and checks them on receive.
// All bit processing advances on sample_point; a stuff violation latches ERR until sync_clr.
module can_stuff_engine #(
    parameter int RUN_LEN = 5,
    parameter int CW      = $clog2(RUN_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_point,
    input  logic          mode,
    input  logic          stuff_en,
    input  logic          sync_clr,
    input  logic          tx_bit,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_out,
    output logic          tx_stuffed,
    output logic          tx_underrun,
    input  logic          rx_bit,
    output logic          rx_data,
    output logic          rx_data_valid,
    output logic          rx_stuff_drop,
    output logic          stuff_err,
    output logic          err_state,
    output logic [CW-1:0] run_count
);

    localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);
    localparam logic [CW-1:0] RUN_ONE = CW'(1);

    typedef enum logic {
        RUN,
        ERR
    } state_t;

    state_t        state, state_next;
    logic          prev_bit, prev_next;
    logic [CW-1:0] run_cnt, run_next;
    logic          pending;
    logic          tx_out_next, tx_stuffed_next, rx_data_next;
    logic          underrun_next, valid_next, drop_next, err_next;

    // Run length after bit b; held at zero while stuffing is disabled.
    function automatic logic [CW-1:0] run_step(input logic b, input logic p,
                                               input logic [CW-1:0] c, input logic en);
        if (!en)
            return '0;
        if (b == p && c != '0)
            return (c == RUN_MAX) ? c : c + RUN_ONE;
        return RUN_ONE;
    endfunction

    assign pending   = stuff_en & (run_cnt == RUN_MAX);
    assign tx_ready  = sample_point & mode & ~pending;
    assign err_state = (state == ERR);
    assign run_count = run_cnt;

    always_comb begin
        state_next      = state;
        prev_next       = prev_bit;
        run_next        = run_cnt;
        tx_out_next     = tx_out;
        tx_stuffed_next = tx_stuffed;
        rx_data_next    = rx_data;
        underrun_next   = 1'b0;
        valid_next      = 1'b0;
        drop_next       = 1'b0;
        err_next        = 1'b0;

        if (sync_clr) begin
            run_next   = '0;
            prev_next  = 1'b1;
            state_next = RUN;
        end else if (sample_point) begin
            if (mode) begin
                if (pending) begin
                    tx_out_next     = ~prev_bit;
                    tx_stuffed_next = 1'b1;
                    run_next        = RUN_ONE;
                    prev_next       = ~prev_bit;
                end else if (tx_valid) begin
                    tx_out_next     = tx_bit;
                    tx_stuffed_next = 1'b0;
                    run_next        = run_step(tx_bit, prev_bit, run_cnt, stuff_en);
                    prev_next       = tx_bit;
                end else begin
                    tx_out_next     = 1'b1;
                    tx_stuffed_next = 1'b0;
                    underrun_next   = 1'b1;
                    run_next        = run_step(1'b1, prev_bit, run_cnt, stuff_en);
                    prev_next       = 1'b1;
                end
            end else if (state == RUN) begin
                if (pending && rx_bit != prev_bit) begin
                    drop_next = 1'b1;
                    run_next  = RUN_ONE;
                    prev_next = rx_bit;
                end else if (pending) begin
                    err_next   = 1'b1;
                    state_next = ERR;
                end else begin
                    rx_data_next = rx_bit;
                    valid_next   = 1'b1;
                    run_next     = run_step(rx_bit, prev_bit, run_cnt, stuff_en);
                    prev_next    = rx_bit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bit      <= 1'b1;
            run_cnt       <= '0;
            tx_out        <= 1'b1;
            tx_stuffed    <= 1'b0;
            rx_data       <= 1'b1;
            tx_underrun   <= 1'b0;
            rx_data_valid <= 1'b0;
            rx_stuff_drop <= 1'b0;
            stuff_err     <= 1'b0;
        end else begin
            prev_bit      <= prev_next;
            run_cnt       <= run_next;
            tx_out        <= tx_out_next;
            tx_stuffed    <= tx_stuffed_next;
            rx_data       <= rx_data_next;
            tx_underrun   <= underrun_next;
            rx_data_valid <= valid_next;
            rx_stuff_drop <= drop_next;
            stuff_err     <= err_next;
        end
    end

endmodule

// File: tb/tb_can_stuff_engine.sv
// Directed bench for can_stuff_engine: RUN_LEN=5 and RUN_LEN=3 instances share stimulus;
// sel chooses which instance's outputs are checked.
module tb_can_stuff_engine;

    logic clk = 1'b0;
    logic rst_n, sample_point, mode, stuff_en, sync_clr, tx_bit, tx_valid, rx_bit;
    logic sel;

    logic       ready_5, out_5, stf_5, und_5, rxd_5, val_5, drop_5, err_5, errst_5;
    logic [2:0] rc_5;
    logic       ready_3, out_3, stf_3, und_3, rxd_3, val_3, drop_3, err_3, errst_3;
    logic [1:0] rc_3;

    logic       o_ready, o_out, o_stf, o_und, o_rxd, o_val, o_drop, o_err, o_errst;
    logic [2:0] o_rc;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clk = ~clk;

    can_stuff_engine #(.RUN_LEN(5)) u5 (
        .clk(clk), .rst_n(rst_n), .sample_point(sample_point), .mode(mode),
        .stuff_en(stuff_en), .sync_clr(sync_clr), .tx_bit(tx_bit), .tx_valid(tx_valid),
        .tx_ready(ready_5), .tx_out(out_5), .tx_stuffed(stf_5), .tx_underrun(und_5),
        .rx_bit(rx_bit), .rx_data(rxd_5), .rx_data_valid(val_5), .rx_stuff_drop(drop_5),
        .stuff_err(err_5), .err_state(errst_5), .run_count(rc_5)
    );

    can_stuff_engine #(.RUN_LEN(3)) u3 (
        .clk(clk), .rst_n(rst_n), .sample_point(sample_point), .mode(mode),
        .stuff_en(stuff_en), .sync_clr(sync_clr), .tx_bit(tx_bit), .tx_valid(tx_valid),
        .tx_ready(ready_3), .tx_out(out_3), .tx_stuffed(stf_3), .tx_underrun(und_3),
        .rx_bit(rx_bit), .rx_data(rxd_3), .rx_data_valid(val_3), .rx_stuff_drop(drop_3),
        .stuff_err(err_3), .err_state(errst_3), .run_count(rc_3)
    );

    assign o_ready = sel ? ready_3 : ready_5;
    assign o_out   = sel ? out_3   : out_5;
    assign o_stf   = sel ? stf_3   : stf_5;
    assign o_und   = sel ? und_3   : und_5;
    assign o_rxd   = sel ? rxd_3   : rxd_5;
    assign o_val   = sel ? val_3   : val_5;
    assign o_drop  = sel ? drop_3  : drop_5;
    assign o_err   = sel ? err_3   : err_5;
    assign o_errst = sel ? errst_3 : errst_5;
    assign o_rc    = sel ? {1'b0, rc_3} : rc_5;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One bit time; tx_ready is captured while sample_point is high.
    task automatic step(input logic v, input logic b, input logic rb, output logic rdy);
        @(negedge clk);
        sample_point = 1'b1;
        tx_valid     = v;
        tx_bit       = b;
        rx_bit       = rb;
        #1 rdy = o_ready;
        @(posedge clk);
        #1;
        sample_point = 1'b0;
        tx_valid     = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk);
        sync_clr = 1'b1;
        @(posedge clk);
        #1 sync_clr = 1'b0;
    endtask

    // Bit i of each vector corresponds to the i-th sample point (or data bit).
    task automatic tx_stream(input string tag, input logic [15:0] data, input int unsigned nd,
                             input logic [15:0] e_out, input logic [15:0] e_stf,
                             input int unsigned ns);
        int unsigned idx = 0;
        logic rdy;
        for (int unsigned i = 0; i < ns; i++) begin
            step(idx < nd, data[idx[3:0]], 1'b1, rdy);
            check({tag, "_ready"}, {7'b0, rdy}, {7'b0, ~e_stf[i]});
            check({tag, "_out"}, {7'b0, o_out}, {7'b0, e_out[i]});
            check({tag, "_stuffed"}, {7'b0, o_stf}, {7'b0, e_stf[i]});
            if (!stuff_en)
                check({tag, "_run0"}, {5'b0, o_rc}, 8'd0);
            if (rdy && idx < nd)
                idx++;
        end
        check({tag, "_consumed"}, 8'(idx), 8'(nd));
    endtask

    task automatic rx_stream(input string tag, input logic [15:0] bus, input int unsigned n,
                             input logic [15:0] e_val, input logic [15:0] e_drop,
                             input logic [15:0] e_err, input logic [15:0] e_errst);
        logic rdy;
        for (int unsigned i = 0; i < n; i++) begin
            step(1'b0, 1'b0, bus[i], rdy);
            check({tag, "_valid"}, {7'b0, o_val}, {7'b0, e_val[i]});
            check({tag, "_drop"}, {7'b0, o_drop}, {7'b0, e_drop[i]});
            check({tag, "_err"}, {7'b0, o_err}, {7'b0, e_err[i]});
            check({tag, "_errst"}, {7'b0, o_errst}, {7'b0, e_errst[i]});
            if (e_val[i])
                check({tag, "_data"}, {7'b0, o_rxd}, {7'b0, bus[i]});
        end
    endtask

    initial begin
        logic rdy;
        rst_n = 1'b0; sample_point = 1'b0; mode = 1'b1; stuff_en = 1'b1;
        sync_clr = 1'b0; tx_bit = 1'b0; tx_valid = 1'b0; rx_bit = 1'b1; sel = 1'b0;
        #12;
        check("rst_tx_out", {7'b0, o_out}, 8'd1);
        check("rst_tx_stuffed", {7'b0, o_stf}, 8'd0);
        check("rst_rx_data", {7'b0, o_rxd}, 8'd1);
        check("rst_pulses", {4'b0, o_und, o_val, o_drop, o_err}, 8'd0);
        check("rst_err_state", {7'b0, o_errst}, 8'd0);
        check("rst_run_count", {5'b0, o_rc}, 8'd0);
        check("rst_tx_ready", {7'b0, o_ready}, 8'd0);
        @(negedge clk) rst_n = 1'b1;

        // TX RUN_LEN=5: 0x6 then 1 -> 0,0,0,0,0,S1,0,1
        clr();
        tx_stream("tx5", 16'h0040, 7, 16'h00A0, 16'h0020, 8);

        // RUN_LEN=3, stuffing off then on
        sel = 1'b1;
        stuff_en = 1'b0;
        clr();
        tx_stream("tx3_nostuff", 16'h00FF, 8, 16'h00FF, 16'h0000, 8);
        stuff_en = 1'b1;
        clr();
        tx_stream("tx3_stuff", 16'h00FF, 8, 16'h0377, 16'h0088, 10);
        sel = 1'b0;

        // Underruns count as recessive bits toward the run
        clr();
        step(1'b1, 1'b0, 1'b1, rdy);
        check("und_first_out", {7'b0, o_out}, 8'd0);
        step(1'b0, 1'b0, 1'b1, rdy);
        check("und_out", {7'b0, o_out}, 8'd1);
        check("und_pulse", {7'b0, o_und}, 8'd1);
        check("und_run", {5'b0, o_rc}, 8'd1);
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, rdy);
        check("und_nopulse", {7'b0, o_und}, 8'd0);
        check("und_run4", {5'b0, o_rc}, 8'd4);
        step(1'b0, 1'b0, 1'b1, rdy);
        check("und_pulse2", {7'b0, o_und}, 8'd1);
        check("und_run5", {5'b0, o_rc}, 8'd5);
        step(1'b1, 1'b1, 1'b1, rdy);
        check("und_stuff_ready", {7'b0, rdy}, 8'd0);
        check("und_stuff_out", {7'b0, o_out}, 8'd0);
        check("und_stuff_flag", {7'b0, o_stf}, 8'd1);
        check("und_stuff_nopulse", {7'b0, o_und}, 8'd0);

        // RX destuff: 1,1,1,1,1,0,1
        mode = 1'b0;
        clr();
        rx_stream("rx_drop", 16'h005F, 7, 16'h005F, 16'h0020, 16'h0000, 16'h0000);
        @(posedge clk);
        #1 check("rx_valid_one_cycle", {7'b0, o_val}, 8'd0);

        // RX stuff error: six 0s then 0,0,1 ignored in ERR
        clr();
        rx_stream("rx_err", 16'h0100, 9, 16'h001F, 16'h0000, 16'h0020, 16'h01E0);
        check("rx_err_run_held", {5'b0, o_rc}, 8'd5);
        clr();
        check("rx_err_cleared", {7'b0, o_errst}, 8'd0);
        check("rx_clr_run", {5'b0, o_rc}, 8'd0);
        check("rx_clr_nopulse", {4'b0, o_und, o_val, o_drop, o_err}, 8'd0);

        // Asynchronous reset while in ERR with non-reset outputs
        rx_stream("rx_err2", 16'h0000, 6, 16'h001F, 16'h0000, 16'h0020, 16'h0020);
        check("pre_rst_tx_out", {7'b0, o_out}, 8'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_err_state", {7'b0, o_errst}, 8'd0);
        check("arst_rx_data", {7'b0, o_rxd}, 8'd1);
        check("arst_tx_out", {7'b0, o_out}, 8'd1);
        check("arst_tx_stuffed", {7'b0, o_stf}, 8'd0);
        check("arst_run_count", {5'b0, o_rc}, 8'd0);
        @(negedge clk) rst_n = 1'b1;

        // sync_clr beats a simultaneous sample point that would underrun
        mode = 1'b1;
        clr();
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, rdy);
        check("pre_clr_run", {5'b0, o_rc}, 8'd3);
        @(negedge clk);
        sync_clr = 1'b1; sample_point = 1'b1; tx_valid = 1'b0;
        @(posedge clk);
        #1 sync_clr = 1'b0; sample_point = 1'b0;
        check("clrwin_underrun", {7'b0, o_und}, 8'd0);
        check("clrwin_tx_out", {7'b0, o_out}, 8'd0);
        check("clrwin_run", {5'b0, o_rc}, 8'd0);
        check("clrwin_pulses", {4'b0, o_und, o_val, o_drop, o_err}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
